// File: rtl/riscv_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// riscv_pkg : shared opcodes, select encodings and FSM states
// Rev 1.0
// ------------------------------------------------------------------
package riscv_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_FENCE  = 7'h0F;
   localparam logic [6:0] OPC_OPIMM  = 7'h13;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_SYSTEM = 7'h73;

   localparam logic [2:0] EXT_I = 3'b000;
   localparam logic [2:0] EXT_B = 3'b001;
   localparam logic [2:0] EXT_J = 3'b010;
   localparam logic [2:0] EXT_S = 3'b011;
   localparam logic [2:0] EXT_U = 3'b100;

   localparam logic [3:0] ALU_ADD = 4'b0000;

   localparam logic [1:0] PC_PLUS4 = 2'b00;
   localparam logic [1:0] PC_ALU   = 2'b01;
   localparam logic [1:0] PC_JALR  = 2'b10;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_LOAD = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;
   localparam logic [1:0] WB_IMM  = 2'b11;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      IC_ALU, IC_LOAD, IC_STORE, IC_BRANCH, IC_JAL,
      IC_JALR, IC_LUI, IC_AUIPC, IC_NOP
   } iclass_t;

   // OP-IMM only honours funct7[5] to select SRAI over SRLI.
   function automatic logic [3:0] alu_from_funct(input logic [2:0] funct3,
                                                 input logic funct7_b5,
                                                 input logic is_reg);
      return {funct7_b5 & (is_reg | (funct3 == 3'b101)), funct3};
   endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ------------------------------------------------------------------
// ctrl_decode : opcode/funct -> instruction class, ext_op, ALU selects
// Rev 1.0
// ------------------------------------------------------------------
module ctrl_decode
   import riscv_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output iclass_t    iclass,
   output logic [2:0] ext_op,
   output logic [3:0] alu_op,
   output logic       alu_a_sel,
   output logic       alu_b_sel,
   output logic       legal
);

   always_comb begin
      iclass    = IC_NOP;
      ext_op    = EXT_I;
      alu_op    = ALU_ADD;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      legal     = 1'b1;
      case (opcode)
         OPC_OP: begin
            iclass = IC_ALU;
            alu_op = alu_from_funct(funct3, funct7[5], 1'b1);
            legal  = (funct7 == 7'h00) ||
                     ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
         end
         OPC_OPIMM: begin
            iclass    = IC_ALU;
            alu_op    = alu_from_funct(funct3, funct7[5], 1'b0);
            alu_b_sel = 1'b1;
         end
         OPC_LOAD: begin
            iclass    = IC_LOAD;
            alu_b_sel = 1'b1;
         end
         OPC_STORE: begin
            iclass    = IC_STORE;
            ext_op    = EXT_S;
            alu_b_sel = 1'b1;
         end
         // Branch target PC+imm goes through the ALU; the compare is external.
         OPC_BRANCH: begin
            iclass    = IC_BRANCH;
            ext_op    = EXT_B;
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
         end
         OPC_JAL: begin
            iclass    = IC_JAL;
            ext_op    = EXT_J;
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
         end
         OPC_JALR: begin
            iclass    = IC_JALR;
            alu_b_sel = 1'b1;
         end
         OPC_LUI: begin
            iclass = IC_LUI;
            ext_op = EXT_U;
         end
         OPC_AUIPC: begin
            iclass    = IC_AUIPC;
            ext_op    = EXT_U;
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
         end
         OPC_FENCE, OPC_SYSTEM: iclass = IC_NOP;
         default:               legal  = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// multicycle_ctrl : multi-cycle RV32I control FSM (ILLEGAL_INST_TRAP_EN adds TRAP)
// Rev 1.0
// ------------------------------------------------------------------
module multicycle_ctrl
   import riscv_pkg::*;
#(
   parameter logic [2:0] RESET_STATE = 3'd0,
   parameter int         MEM_TIMEOUT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst,
   input  logic        mem_ready,
   input  logic        br_taken,
   output logic [2:0]  ext_op,
   output logic [3:0]  alu_op,
   output logic        alu_a_sel,
   output logic        alu_b_sel,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic        mem_req,
   output logic        mem_we,
   output logic [1:0]  mem_size,
   output logic        rf_we,
   output logic [1:0]  wb_sel,
   output logic        mem_err,
   output logic        illegal
);

   state_t      r_state;
   logic [15:0] r_wait;
   iclass_t     w_iclass;
   logic [2:0]  w_ext;
   logic [3:0]  w_aop;
   logic        w_asel, w_bsel, w_legal, w_rf_wr;
   logic        w_unused;

   ctrl_decode u_decode (
      .opcode    (inst[6:0]),
      .funct3    (inst[14:12]),
      .funct7    (inst[31:25]),
      .iclass    (w_iclass),
      .ext_op    (w_ext),
      .alu_op    (w_aop),
      .alu_a_sel (w_asel),
      .alu_b_sel (w_bsel),
      .legal     (w_legal)
   );

   assign w_unused = ^{inst[24:15], w_legal};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= state_t'(RESET_STATE);
      end else begin
         case (r_state)
            ST_FETCH:  if (mem_ready) r_state <= ST_DECODE;
`ifdef ILLEGAL_INST_TRAP_EN
            ST_DECODE: r_state <= w_legal ? ST_EXEC : ST_TRAP;
            ST_TRAP:   r_state <= ST_TRAP;
`else
            ST_DECODE: r_state <= ST_EXEC;
`endif
            ST_EXEC: begin
               case (w_iclass)
                  IC_ALU, IC_AUIPC:  r_state <= ST_WB;
                  IC_LOAD, IC_STORE: r_state <= ST_MEM;
                  default:           r_state <= ST_FETCH;
               endcase
            end
            ST_MEM:    if (mem_ready) r_state <= (w_iclass == IC_STORE) ? ST_FETCH : ST_WB;
            default:   r_state <= ST_FETCH;
         endcase
      end
   end

   // Counts cycles the current request has waited; any gap or completion restarts it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  r_wait <= '0;
      else if (mem_req && !mem_ready && r_wait != 16'hFFFF) r_wait <= r_wait + 16'd1;
      else if (!mem_req || mem_ready)           r_wait <= '0;
   end

   assign mem_err = (MEM_TIMEOUT != 0) && mem_req && (r_wait == 16'(MEM_TIMEOUT));

`ifdef ILLEGAL_INST_TRAP_EN
   assign illegal = (r_state == ST_TRAP);
`else
   assign illegal = 1'b0;
`endif

   always_comb begin
      ext_op    = EXT_I;
      alu_op    = ALU_ADD;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = PC_PLUS4;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_size  = 2'b10;
      w_rf_wr   = 1'b0;
      wb_sel    = WB_ALU;
      case (r_state)
         ST_FETCH: begin
            mem_req = ~rst;
            ir_we   = mem_ready & ~rst;
         end
         ST_DECODE: begin
            ext_op    = w_ext;
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
         end
         ST_EXEC: begin
            ext_op    = w_ext;
            alu_op    = w_aop;
            alu_a_sel = w_asel;
            alu_b_sel = w_bsel;
            case (w_iclass)
               IC_BRANCH: begin
                  pc_we  = 1'b1;
                  pc_sel = br_taken ? PC_ALU : PC_PLUS4;
               end
               IC_JAL, IC_JALR: begin
                  pc_we   = 1'b1;
                  pc_sel  = (w_iclass == IC_JAL) ? PC_ALU : PC_JALR;
                  w_rf_wr = 1'b1;
                  wb_sel  = WB_PC4;
               end
               IC_LUI: begin
                  pc_we   = 1'b1;
                  w_rf_wr = 1'b1;
                  wb_sel  = WB_IMM;
               end
               IC_NOP:  pc_we = 1'b1;
               default: ;
            endcase
         end
         ST_MEM: begin
            ext_op    = w_ext;
            alu_op    = w_aop;
            alu_a_sel = w_asel;
            alu_b_sel = w_bsel;
            mem_req   = 1'b1;
            mem_we    = (w_iclass == IC_STORE);
            mem_size  = inst[13:12];
            pc_we     = (w_iclass == IC_STORE) & mem_ready;
         end
         ST_WB: begin
            ext_op    = w_ext;
            alu_op    = w_aop;
            alu_a_sel = w_asel;
            alu_b_sel = w_bsel;
            w_rf_wr   = 1'b1;
            wb_sel    = (w_iclass == IC_LOAD) ? WB_LOAD : WB_ALU;
            pc_we     = 1'b1;
         end
         default: ;
      endcase
   end

   assign rf_we = w_rf_wr & (inst[11:7] != 5'd0);

endmodule
`default_nettype wire
